// File: rtl/pic_pkg.sv
// pic_pkg: shared types and defaults for the interrupt acknowledge sequencer
package pic_pkg;
  typedef logic [2:0] level_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK1, S_GAP, S_ACK2} state_e;
  localparam level_t SPUR_LVL_DEF = 3'd7;
endpackage

// File: rtl/isr_priority_find.sv
// isr_priority_find: highest-priority set isr bit, priority starting just above lowest_prio
module isr_priority_find
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  level_t     lowest_prio,
  output logic       found,
  output level_t     level
);
  level_t l;
  // scan from lowest priority upward so the highest-priority hit is written last
  always_comb begin
    found = 1'b0;
    level = lowest_prio;
    l = '0;
    for (int i = 7; i >= 0; i--) begin
      l = lowest_prio + 3'(i) + 3'd1;
      if (isr[l]) begin
        found = 1'b1;
        level = l;
      end
    end
  end
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: two-pulse INTA handshake, in-service tracking and EOI handling
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int     TIMEOUT_CYC = 255,
  parameter level_t SPUR_LVL    = SPUR_LVL_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  level_t     req_level,
  input  logic       inta_n,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  level_t     eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irr_clr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output level_t     lowest_prio
);
  state_e     state_q, state_d;
  level_t     level_q, level_d, lowest_prio_q, lowest_prio_d, found_lvl;
  logic       spur_q, spur_d, inta_q, int_out_q, int_out_d, data_oe_q, data_oe_d;
  logic       found, fall, rise;
  logic [7:0] isr_q, isr_d, irr_clr_q, irr_clr_d, data_out_q, data_out_d;
  logic [7:0] set_m, aeoi_m, eoi_m;
  logic [9:0] cnt_q, cnt_d;

  isr_priority_find u_find (
    .isr        (isr_q),
    .lowest_prio(lowest_prio_q),
    .found      (found),
    .level      (found_lvl)
  );

  // next-state: acknowledge FSM, gap timeout, EOI clears and rotation
  always_comb begin
    fall = inta_q & ~inta_n;
    rise = ~inta_q & inta_n;
    state_d = state_q;
    level_d = level_q;
    spur_d = spur_q;
    cnt_d = cnt_q;
    int_out_d = int_out_q;
    set_m = '0;
    aeoi_m = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_REQ;
        int_out_d = 1'b1;
      end
      S_REQ: if (fall) begin
        state_d = S_ACK1;
        level_d = req_valid ? req_level : SPUR_LVL;
        spur_d = ~req_valid;
        int_out_d = 1'b0;
        cnt_d = '0;
        set_m = req_valid ? 8'd1 << req_level : '0;
      end else if (!req_valid) begin
        state_d = S_IDLE;
        int_out_d = 1'b0;
      end
      S_ACK1: if (rise) state_d = S_GAP;
      S_GAP: if (fall) state_d = S_ACK2;
        else if (cnt_q == 10'(TIMEOUT_CYC - 1)) state_d = S_IDLE;
        else cnt_d = cnt_q + 10'd1;
      S_ACK2: if (rise) begin
        state_d = S_IDLE;
        aeoi_m = (aeoi && !spur_q) ? 8'd1 << level_q : '0;
      end
      default: state_d = S_IDLE;
    endcase
    eoi_m = !eoi_valid ? '0 : eoi_specific ? 8'd1 << eoi_level : found ? 8'd1 << found_lvl : '0;
    lowest_prio_d = !(eoi_valid && eoi_rotate) ? lowest_prio_q :
                    eoi_specific ? eoi_level : found ? found_lvl : lowest_prio_q;
    isr_d = (isr_q & ~(eoi_m | aeoi_m)) | set_m;
    irr_clr_d = set_m;
    data_oe_d = (state_d == S_ACK2) && !inta_n;
    data_out_d = data_oe_d ? {vec_base, level_d} : '0;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      spur_q <= 1'b0;
      cnt_q <= '0;
      inta_q <= 1'b1;
      int_out_q <= 1'b0;
      isr_q <= '0;
      irr_clr_q <= '0;
      data_out_q <= '0;
      data_oe_q <= 1'b0;
      lowest_prio_q <= 3'd7;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      spur_q <= spur_d;
      cnt_q <= cnt_d;
      inta_q <= inta_n;
      int_out_q <= int_out_d;
      isr_q <= isr_d;
      irr_clr_q <= irr_clr_d;
      data_out_q <= data_out_d;
      data_oe_q <= data_oe_d;
      lowest_prio_q <= lowest_prio_d;
    end
  end

  assign int_out = int_out_q;
  assign isr = isr_q;
  assign irr_clr = irr_clr_q;
  assign data_out = data_out_q;
  assign data_oe = data_oe_q;
  assign lowest_prio = lowest_prio_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed checks of the INTA sequencer
module tb_inta_sequencer;
  import pic_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n, req_valid, inta_n, aeoi, eoi_valid, eoi_specific, eoi_rotate;
  level_t     req_level, eoi_level, lowest_prio;
  logic [4:0] vec_base;
  logic       int_out, data_oe;
  logic [7:0] isr, irr_clr, data_out;
  int         passed = 0, total = 0;
  logic       oe_seen;

  inta_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_level(req_level),
    .inta_n(inta_n), .vec_base(vec_base), .aeoi(aeoi), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .int_out(int_out), .isr(isr), .irr_clr(irr_clr), .data_out(data_out),
    .data_oe(data_oe), .lowest_prio(lowest_prio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // full two-pulse acknowledge of one level, ending back in IDLE
  task automatic ack_seq(input level_t l);
    req_valid = 1'b1; req_level = l; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; req_valid = 1'b0; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_level = '0; inta_n = 1'b1; vec_base = 5'h08;
    aeoi = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = '0;
    tick(); tick();
    chk("rst_int_out", int_out, 0);
    chk("rst_isr", isr, 8'h00);
    chk("rst_irr_clr", irr_clr, 8'h00);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_lowest_prio", lowest_prio, 3'd7);
    reset_n = 1'b1;
    // level 3 basic acknowledge
    req_valid = 1'b1; req_level = 3'd3; tick();
    chk("l3_int_out_req", int_out, 1);
    inta_n = 1'b0; tick();
    chk("l3_irr_clr", irr_clr, 8'h08);
    chk("l3_isr_ack1", isr, 8'h08);
    chk("l3_int_out_ack1", int_out, 0);
    tick();
    chk("l3_irr_clr_pulse", irr_clr, 8'h00);
    chk("l3_oe_ack1", data_oe, 0);
    inta_n = 1'b1; req_valid = 1'b0; tick();
    chk("l3_oe_gap", data_oe, 0);
    inta_n = 1'b0; tick();
    chk("l3_data_out", data_out, 8'h43);
    chk("l3_data_oe", data_oe, 1);
    inta_n = 1'b1; tick();
    chk("l3_oe_idle", data_oe, 0);
    chk("l3_isr_kept", isr, 8'h08);
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
    chk("spec_eoi_isr", isr, 8'h00);
    chk("spec_eoi_lp", lowest_prio, 3'd7);
    // auto-EOI level 5
    aeoi = 1'b1; req_valid = 1'b1; req_level = 3'd5; tick();
    inta_n = 1'b0; tick();
    chk("aeoi_isr_p1", isr, 8'h20);
    inta_n = 1'b1; req_valid = 1'b0; tick();
    inta_n = 1'b0; tick();
    chk("aeoi_data_out", data_out, 8'h45);
    chk("aeoi_isr_ack2", isr, 8'h20);
    inta_n = 1'b1; tick();
    chk("aeoi_isr_done", isr, 8'h00);
    aeoi = 1'b0;
    // spurious: request withdrawn on the first falling edge
    req_valid = 1'b1; req_level = 3'd2; tick();
    req_valid = 1'b0; inta_n = 1'b0; tick();
    chk("spur_irr_clr", irr_clr, 8'h00);
    chk("spur_isr", isr, 8'h00);
    chk("spur_int_out", int_out, 0);
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("spur_data_out", data_out, 8'h47);
    chk("spur_data_oe", data_oe, 1);
    inta_n = 1'b1; tick();
    chk("spur_isr_end", isr, 8'h00);
    // request dropped before any INTA returns to IDLE
    req_valid = 1'b1; req_level = 3'd6; tick();
    req_valid = 1'b0; tick();
    chk("drop_int_out", int_out, 0);
    chk("drop_state", dut.state_q, S_IDLE);
    // rotating non-specific EOI
    ack_seq(3'd1);
    ack_seq(3'd3);
    chk("rot_isr_setup", isr, 8'h0A);
    eoi_valid = 1'b1; eoi_rotate = 1'b1; tick();
    chk("rot1_isr", isr, 8'h08);
    chk("rot1_lp", lowest_prio, 3'd1);
    tick();
    chk("rot2_isr", isr, 8'h00);
    chk("rot2_lp", lowest_prio, 3'd3);
    tick();
    chk("rot_empty_lp", lowest_prio, 3'd3);
    eoi_valid = 1'b0; eoi_rotate = 1'b0;
    // same-level EOI on ACK1 entry: set wins; then gap timeout
    req_valid = 1'b1; req_level = 3'd4; tick();
    inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
    chk("coll_isr", isr, 8'h10);
    inta_n = 1'b1; req_valid = 1'b0; tick();
    oe_seen = data_oe;
    for (int i = 0; i < 15; i++) begin
      tick();
      oe_seen = oe_seen | data_oe;
    end
    chk("to_still_gap", dut.state_q, S_GAP);
    tick();
    chk("to_idle", dut.state_q, S_IDLE);
    chk("to_oe_never", oe_seen | data_oe, 0);
    chk("to_isr_kept", isr, 8'h10);
    // reset during ACK2
    req_valid = 1'b1; req_level = 3'd6; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; req_valid = 1'b0; tick();
    inta_n = 1'b0; tick();
    chk("rst2_pre_oe", data_oe, 1);
    reset_n = 1'b0; tick();
    chk("rst2_oe", data_oe, 0);
    chk("rst2_data_out", data_out, 8'h00);
    chk("rst2_isr", isr, 8'h00);
    chk("rst2_lp", lowest_prio, 3'd7);
    chk("rst2_state", dut.state_q, S_IDLE);
    // INTA edge while IDLE is ignored
    reset_n = 1'b1; inta_n = 1'b1; tick();
    inta_n = 1'b0; tick(); tick();
    chk("idle_inta_state", dut.state_q, S_IDLE);
    chk("idle_inta_oe", data_oe, 0);
    chk("idle_inta_irr", irr_clr, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
